// File: rtl/gray_rx_tracker.sv
// Receive-side tracker for a Gray-coded position bus: synchronizes, decodes,
// classifies each change as up/down/illegal and keeps a wrapping position count.
module gray_rx_tracker #(
  parameter int WIDTH = 3,
  parameter int POS_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gin,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bout,
  output logic             bout_valid,
  output logic             up,
  output logic             dn,
  output logic             jump,
  output logic             err,
  output logic [POS_W-1:0] pos
);

  typedef enum logic [1:0] {FILL0, FILL1, LOAD, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] bnew;
  logic [WIDTH-1:0] d;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bnew = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bnew[i] = ^(s2 >> i);
    end
  end

  assign d = bnew - bout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL0;
      s1         <= '0;
      s2         <= '0;
      bout       <= '0;
      bout_valid <= 1'b0;
      up         <= 1'b0;
      dn         <= 1'b0;
      jump       <= 1'b0;
      err        <= 1'b0;
      pos        <= '0;
    end else begin
      s1   <= gin;
      s2   <= s1;
      up   <= 1'b0;
      dn   <= 1'b0;
      jump <= 1'b0;
      if (err_clr) begin
        err <= 1'b0;
      end
      case (state)
        FILL0: state <= FILL1;
        FILL1: state <= LOAD;
        LOAD: begin
          bout       <= bnew;
          bout_valid <= 1'b1;
          state      <= RUN;
        end
        RUN: begin
          // A fresh illegal change overrides a same-cycle clear.
          if (d == WIDTH'(1)) begin
            up   <= 1'b1;
            bout <= bnew;
            pos  <= pos + POS_W'(1);
          end else if (d == '1) begin
            dn   <= 1'b1;
            bout <= bnew;
            pos  <= pos - POS_W'(1);
          end else if (d != '0) begin
            jump <= 1'b1;
            err  <= 1'b1;
            bout <= bnew;
          end
        end
        default: state <= FILL0;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_rx_tracker.sv
// Directed self-checking bench for gray_rx_tracker using an expectation queue
// filled as each Gray step is driven and drained when it is classified.
module tb_gray_rx_tracker;

  logic       clk;
  logic       rst_n;
  logic [2:0] gin;
  logic       err_clr;
  logic [2:0] bout;
  logic       bout_valid;
  logic       up;
  logic       dn;
  logic       jump;
  logic       err;
  logic [7:0] pos;

  gray_rx_tracker #(.WIDTH(3), .POS_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .gin(gin), .err_clr(err_clr),
    .bout(bout), .bout_valid(bout_valid), .up(up), .dn(dn),
    .jump(jump), .err(err), .pos(pos)
  );

  typedef struct {
    string      tag;
    logic [2:0] bout;
    logic       up;
    logic       dn;
    logic       jump;
    logic       err;
    logic [7:0] pos;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails  = 0;

  // Gray code to binary, indexed by the Gray value.
  int         g2b[8] = '{0, 1, 3, 2, 7, 6, 4, 5};
  logic [2:0] mbout;
  logic [7:0] mpos;
  logic       merr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbq.size() == 0) begin
      checkVal("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      checkVal({e.tag, "_bout"}, 32'(bout), 32'(e.bout));
      checkVal({e.tag, "_up"},   32'(up),   32'(e.up));
      checkVal({e.tag, "_dn"},   32'(dn),   32'(e.dn));
      checkVal({e.tag, "_jump"}, 32'(jump), 32'(e.jump));
      checkVal({e.tag, "_err"},  32'(err),  32'(e.err));
      checkVal({e.tag, "_pos"},  32'(pos),  32'(e.pos));
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, "_bout"},  32'(bout),       32'd0);
    checkVal({tag, "_valid"}, 32'(bout_valid), 32'd0);
    checkVal({tag, "_up"},    32'(up),         32'd0);
    checkVal({tag, "_dn"},    32'(dn),         32'd0);
    checkVal({tag, "_jump"},  32'(jump),       32'd0);
    checkVal({tag, "_err"},   32'(err),        32'd0);
    checkVal({tag, "_pos"},   32'(pos),        32'd0);
  endtask

  // Release reset at a falling edge and verify the three-edge startup.
  task automatic releaseAndStartup(input string tag, input logic [2:0] expb);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkVal({tag, "_valid_e1"}, 32'(bout_valid), 32'd0);
    @(posedge clk); #1;
    checkVal({tag, "_valid_e2"}, 32'(bout_valid), 32'd0);
    @(posedge clk); #1;
    checkVal({tag, "_valid_e3"}, 32'(bout_valid), 32'd1);
    checkVal({tag, "_bout_e3"},  32'(bout),       32'(expb));
    checkVal({tag, "_pulses"},   32'({up, dn, jump}), 32'd0);
    checkVal({tag, "_pos"},      32'(pos),        32'd0);
    mbout = expb;
    mpos  = 8'd0;
    merr  = 1'b0;
  endtask

  task automatic doReset(input string tag, input logic [2:0] g, input logic [2:0] expb);
    @(negedge clk);
    rst_n   = 1'b0;
    gin     = g;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues({tag, "_rst"});
    releaseAndStartup(tag, expb);
  endtask

  // Drive one Gray value, queue the model's verdict, compare at the
  // classification edge and confirm the pulses last a single cycle.
  task automatic applyStimulus(input string tag, input logic [2:0] g, input logic clr);
    exp_t e;
    int   nb;
    int   d;
    @(negedge clk);
    gin = g;
    nb  = g2b[g];
    d   = (nb - int'(mbout) + 8) % 8;
    e.tag = tag; e.up = 1'b0; e.dn = 1'b0; e.jump = 1'b0;
    if (d == 1) begin
      e.up = 1'b1; mbout = 3'(nb); mpos = mpos + 8'd1;
    end else if (d == 7) begin
      e.dn = 1'b1; mbout = 3'(nb); mpos = mpos - 8'd1;
    end else if (d != 0) begin
      e.jump = 1'b1; mbout = 3'(nb); merr = 1'b1;
    end else if (clr) begin
      merr = 1'b0;
    end
    if (clr && d != 0 && e.jump == 1'b0) merr = 1'b0;
    e.bout = mbout; e.pos = mpos; e.err = merr;
    sbq.push_back(e);
    repeat (2) @(posedge clk);
    if (clr) begin
      @(negedge clk);
      err_clr = 1'b1;
    end
    @(posedge clk); #1;
    err_clr = 1'b0;
    checkOutput();
    @(posedge clk); #1;
    checkVal({tag, "_pulse_drop"}, 32'({up, dn, jump}), 32'd0);
  endtask

  initial begin
    logic [2:0] fwd[8];
    logic [2:0] rev[8];
    fwd = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    rev = '{3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000};
    rst_n = 1'b0; gin = 3'b110; err_clr = 1'b0;
    mbout = '0; mpos = '0; merr = 1'b0;

    $display("[TB] startup baseline");
    #1;
    checkResetValues("por");
    doReset("start110", 3'b110, 3'd4);

    $display("[TB] forward sequence");
    doReset("fwd", 3'b000, 3'd0);
    for (int i = 0; i < 8; i++) applyStimulus($sformatf("fwd%0d", i), fwd[i], 1'b0);
    checkVal("fwd_final_pos", 32'(pos), 32'd8);
    checkVal("fwd_final_err", 32'(err), 32'd0);

    $display("[TB] reverse and wrap");
    doReset("rev", 3'b000, 3'd0);
    applyStimulus("rev0", rev[0], 1'b0);
    checkVal("rev_first_bout", 32'(bout), 32'd7);
    checkVal("rev_first_pos",  32'(pos),  32'hFF);
    for (int i = 1; i < 8; i++) applyStimulus($sformatf("rev%0d", i), rev[i], 1'b0);
    checkVal("rev_final_pos", 32'(pos), 32'hF8);

    $display("[TB] illegal jumps and error clear");
    doReset("jmpA", 3'b000, 3'd0);
    applyStimulus("jmp_0to2", 3'b011, 1'b0);
    checkVal("jmp_0to2_bout", 32'(bout), 32'd2);
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    merr = 1'b0;
    checkVal("errclr_alone", 32'(err), 32'd0);
    checkVal("errclr_pos_kept", 32'(pos), 32'd0);
    doReset("jmpB", 3'b000, 3'd0);
    applyStimulus("jmp_0to3", 3'b010, 1'b0);
    applyStimulus("jmp_clr_same", 3'b000, 1'b1);
    checkVal("set_beats_clr", 32'(err), 32'd1);

    $display("[TB] mid-operation reset");
    doReset("mid", 3'b000, 3'd0);
    for (int i = 0; i < 5; i++) applyStimulus($sformatf("mid%0d", i), fwd[i], 1'b0);
    checkVal("mid_pos5", 32'(pos), 32'd5);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkResetValues("mid_async");
    gin = 3'b101;
    repeat (2) @(posedge clk);
    releaseAndStartup("mid_restart", 3'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
